silent_sequencer: RTL

- Frame-level controller for the silencer step calculator.
- On each update trigger it latches a consistent set of silencer settings and issues the DIN_VALID start pulse.
- It streams DEPTH intensity/phase samples from the upstream drive buffer, then waits until the calculator has returned all DEPTH results.
- It queues one early trigger, counts triggers that are dropped, and guards the calculator's dividers against a zero divisor.

---
 rtl/silent_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/silent_sequencer.sv
// silent_sequencer: frame-level controller for the silencer step calculator.
//
// On a frame trigger it applies the shadowed silencer settings, pulses
// DIN_VALID, streams DEPTH {intensity, phase} samples out of the drive buffer
// and then waits for the calculator to return DEPTH DOUT_VALID beats.  A
// single early trigger is queued; further triggers while busy are dropped.
// A watchdog aborts a frame whose results never arrive.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   UPDATE                         frame trigger
//   SET_UPDATE, SET_*              shadow-register load strobe and values
//   MEM_ADDR / MEM_DATA            drive-buffer read port (1-cycle latency)
//   DIN_VALID                      start pulse to the calculator
//   INTENSITY_OUT / PHASE_OUT      streamed sample
//   *_FIXED, *_S                   settings applied for the current frame
//   CALC_DOUT_VALID                calculator result beat
//   BUSY, FRAME_DONE, TIMEOUT_ERR  status
//
// Build option: define SILENT_SEQ_OVERRUN_CNT_EN to add OVERRUN_CLR and the
// saturating dropped-trigger counter OVERRUN_CNT.
module silent_sequencer #(
  parameter int DEPTH         = 249,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     UPDATE,
  input  logic                     SET_UPDATE,
  input  logic [15:0]              SET_UPDATE_RATE_INTENSITY,
  input  logic [15:0]              SET_UPDATE_RATE_PHASE,
  input  logic [15:0]              SET_COMPLETION_STEPS_INTENSITY,
  input  logic [15:0]              SET_COMPLETION_STEPS_PHASE,
  input  logic                     SET_FIXED_COMPLETION_STEPS,
  output logic [$clog2(DEPTH)-1:0] MEM_ADDR,
  input  logic [23:0]              MEM_DATA,
  output logic                     DIN_VALID,
  output logic [15:0]              INTENSITY_OUT,
  output logic [7:0]               PHASE_OUT,
  output logic [15:0]              UPDATE_RATE_INTENSITY_FIXED,
  output logic [15:0]              UPDATE_RATE_PHASE_FIXED,
  output logic [15:0]              COMPLETION_STEPS_INTENSITY_S,
  output logic [15:0]              COMPLETION_STEPS_PHASE_S,
  output logic                     FIXED_COMPLETION_STEPS_S,
  input  logic                     CALC_DOUT_VALID,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
  output logic                     TIMEOUT_ERR
`ifdef SILENT_SEQ_OVERRUN_CNT_EN
  ,
  input  logic                     OVERRUN_CLR,
  output logic [15:0]              OVERRUN_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] BEAT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] WD_LAST   = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q;
  logic [CW-1:0] beat_q;
  logic [TW-1:0] wd_q;
  logic          pending_q;
  logic          start;
  logic          wd_expire;

  logic [15:0]   sh_rate_i, sh_rate_p, sh_steps_i, sh_steps_p;
  logic          sh_fixed;
  logic [15:0]   src_rate_i, src_rate_p, src_steps_i, src_steps_p;
  logic          src_fixed;

  logic [15:0]   intensity_p1;
  logic [7:0]    phase_p1;

  // A zero completion-step count would divide by zero in the calculator.
  function automatic logic [15:0] clamp_steps(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // A strobe coincident with the start wins over the older shadow contents.
  always_comb begin
    src_rate_i  = SET_UPDATE ? SET_UPDATE_RATE_INTENSITY      : sh_rate_i;
    src_rate_p  = SET_UPDATE ? SET_UPDATE_RATE_PHASE          : sh_rate_p;
    src_steps_i = SET_UPDATE ? SET_COMPLETION_STEPS_INTENSITY : sh_steps_i;
    src_steps_p = SET_UPDATE ? SET_COMPLETION_STEPS_PHASE     : sh_steps_p;
    src_fixed   = SET_UPDATE ? SET_FIXED_COMPLETION_STEPS     : sh_fixed;
  end

  always_comb begin
    state_d    = state_q;
    DIN_VALID  = 1'b0;
    MEM_ADDR   = '0;
    FRAME_DONE = 1'b0;
    start      = 1'b0;
    wd_expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (UPDATE || pending_q) begin
          start   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        DIN_VALID = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        // Address runs one ahead of the sample index to hide the read latency.
        MEM_ADDR = (k_q == LAST_IDX) ? LAST_IDX : k_q + 1'b1;
        if (k_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (beat_q == BEAT_FULL) begin
          FRAME_DONE = 1'b1;
          state_d    = IDLE;
        end else if (wd_q == WD_LAST) begin
          wd_expire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      wd_q        <= '0;
      pending_q   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= (state_q == STREAM) ? k_q + 1'b1 : '0;
      wd_q    <= (state_q == DRAIN) ? wd_q + 1'b1 : '0;
      // Fixed-mode results can start during STREAM, so beats count from LOAD.
      if (state_q == IDLE)
        beat_q <= '0;
      else if (CALC_DOUT_VALID && beat_q != BEAT_FULL)
        beat_q <= beat_q + 1'b1;
      if (start)
        pending_q <= 1'b0;
      else if (BUSY && UPDATE)
        pending_q <= 1'b1;
      if (wd_expire) TIMEOUT_ERR <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_rate_i                    <= 16'hFFFF;
      sh_rate_p                    <= 16'hFFFF;
      sh_steps_i                   <= 16'd1;
      sh_steps_p                   <= 16'd1;
      sh_fixed                     <= 1'b0;
      UPDATE_RATE_INTENSITY_FIXED  <= 16'hFFFF;
      UPDATE_RATE_PHASE_FIXED      <= 16'hFFFF;
      COMPLETION_STEPS_INTENSITY_S <= 16'd1;
      COMPLETION_STEPS_PHASE_S     <= 16'd1;
      FIXED_COMPLETION_STEPS_S     <= 1'b0;
    end else begin
      if (SET_UPDATE) begin
        sh_rate_i  <= SET_UPDATE_RATE_INTENSITY;
        sh_rate_p  <= SET_UPDATE_RATE_PHASE;
        sh_steps_i <= SET_COMPLETION_STEPS_INTENSITY;
        sh_steps_p <= SET_COMPLETION_STEPS_PHASE;
        sh_fixed   <= SET_FIXED_COMPLETION_STEPS;
      end
      // Applied settings only change on leaving IDLE: stable for a whole frame.
      if (start) begin
        UPDATE_RATE_INTENSITY_FIXED  <= src_rate_i;
        UPDATE_RATE_PHASE_FIXED      <= src_rate_p;
        COMPLETION_STEPS_INTENSITY_S <= clamp_steps(src_steps_i);
        COMPLETION_STEPS_PHASE_S     <= clamp_steps(src_steps_p);
        FIXED_COMPLETION_STEPS_S     <= src_fixed;
      end
    end
  end

  // Stage p1: registered read data, forced to zero outside the stream window.
  always_ff @(posedge CLK) begin
    if (RST || state_q != STREAM) begin
      intensity_p1 <= '0;
      phase_p1     <= '0;
    end else begin
      intensity_p1 <= MEM_DATA[23:8];
      phase_p1     <= MEM_DATA[7:0];
    end
  end

  assign INTENSITY_OUT = intensity_p1;
  assign PHASE_OUT     = phase_p1;

`ifdef SILENT_SEQ_OVERRUN_CNT_EN
  logic drop;
  assign drop = BUSY && UPDATE && pending_q;

  always_ff @(posedge CLK) begin
    if (RST)
      OVERRUN_CNT <= '0;
    else if (OVERRUN_CLR)
      OVERRUN_CNT <= drop ? 16'd1 : 16'd0;
    else if (drop && OVERRUN_CNT != 16'hFFFF)
      OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
  end
`endif

endmodule
